alu_exec_sequencer: RTL and testbench
=====================================

ALU_EXEC_SEQUENCER -- requirements
Module: alu_exec_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: register/ALU width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_W, default 16: byte-address width of the memory port.
REQ-003 Clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  one-cycle pulse; begin execution at StartAddr.
REQ-006 StartAddr  in  ADDR_W  initial PC.
REQ-007 Mem_Addr  out  ADDR_W  byte address.
REQ-008 Mem_CS  out  1  active-high access strobe.
REQ-009 Mem_WR  out  1  1 = write, 0 = read; valid only with Mem_CS.
REQ-010 Mem_WrData  out  8  write byte.
REQ-011 Mem_RdData  in  8  read byte, valid exactly one cycle after a read strobe.
REQ-012 Busy  out  1  high from the cycle after accepted Start until HALT.
REQ-013 Halted  out  1  high after HALT retires, until next Start.
REQ-014 Flags  out  4  {Z,C,N,O}.
REQ-015 PC  out  ADDR_W; IROut  out  16  current instruction.
REQ-016 DbgSel  in  3 / DbgData  out  DATA_W: combinational read of register R[DbgSel].

Function
REQ-017 Eight registers R0..R7 of DATA_W bits; no hardwired-zero register.
REQ-018 States IDLE, FETCH0, FETCH1, FETCH2, EXEC, MEM, HALT; Start SHALL be accepted only in IDLE or HALT (ignored otherwise); acceptance loads PC=StartAddr, clears Halted, enters FETCH0.
REQ-019 FETCH0: read PC. FETCH1: IR[7:0]<=Mem_RdData, read PC+1. FETCH2: IR[15:8]<=Mem_RdData, PC<=PC+2. Then EXEC.
REQ-020 Encoding: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8, [8:0] simm9.
REQ-021 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd=rs1 op rs2); 6 LSL, 7 LSR (rd=rs1 shifted by 1); 8 LDI rd=zero-extended imm8; 9 LD; 10 ST; 11 BZ; 15 HALT; 12-14 SHALL execute as NOP.
REQ-022 Opcodes 1-7 SHALL write rd and Flags in EXEC; all other opcodes SHALL leave Flags unchanged.
REQ-023 Z=result==0, N=result MSB; ADD C=carry-out; SUB C=borrow (rs1<rs2 unsigned); O=signed overflow for ADD/SUB; LSL C=shifted-out MSB, LSR C=shifted-out LSB; O=0 for logic/shift, C=0 for logic.
REQ-024 Single-cycle ops (0-8, 11) SHALL take 4 cycles FETCH0-to-next-FETCH0.
REQ-025 LD: MEM state issues DATA_W/8 byte reads at R[rs1]+i, i=0..DATA_W/8-1, little-endian; rd written on final captured byte; total 5+DATA_W/8 cycles.
REQ-026 ST: MEM state writes byte i of R[rs2] to R[rs1]+i, one byte per cycle, little-endian; total 4+DATA_W/8 cycles.
REQ-027 BZ: if Z=1, PC<=PC+sign-extended simm9 (PC already advanced by 2); else no change.
REQ-028 All PC and address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-029 HALT: enter HALT, Busy=0, Halted=1, Mem_CS=0; registers and Flags retained.
REQ-030 Mem_CS SHALL be 0 in IDLE, EXEC and HALT.

Reset
REQ-031 Reset_n low SHALL immediately force state IDLE, PC=0, IR=0, R0..R7=0, Flags=0, Busy=0, Halted=0, Mem_CS=0, Mem_WR=0, Mem_Addr=0, Mem_WrData=0, including mid-instruction or mid-MEM burst.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the opcode and state enumerations and flag bit indices.
REQ-033 The ALU SHALL be a combinational sub-module alu_seq_alu (DATA_W-parametrised) returning result and {Z,C,N,O}.

Verification
REQ-034 Reset_n asserted during LD burst -> next cycle Mem_CS=0, Busy=0, DbgData of all regs=0x0000.
REQ-035 mem[0x20..0x21]=FF,FF; LDI R1,0x20; LD R2,[R1]; LDI R3,1; ADD R4,R2,R3 -> R4=0x0000, Flags Z=1,C=1,N=0,O=0.
REQ-036 LDI R1,5; LDI R2,7; SUB R3,R1,R2 -> R3=0xFFFE, Z=0,C=1,N=1,O=0.
REQ-037 R4=0xBEEF, R5=0x0040; ST [R5],R4 -> writes 0xEF@0x0040 then 0xBE@0x0041 in consecutive cycles; LD back -> 0xBEEF.
REQ-038 StartAddr=0xFFFE, BZ with Z=1, simm9=-4 -> fetch at 0xFFFE/0xFFFF, PC wraps to 0x0000, then PC=0xFFFC.
REQ-039 HALT -> Busy=0, Halted=1; Start ignored while Busy; Start in HALT restarts with Halted=0 next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU execution sequencer: opcodes, FSM states, flag bit positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LSL  = 4'd6,
    OP_LSR  = 4'd7,
    OP_LDI  = 4'd8,
    OP_LD   = 4'd9,
    OP_ST   = 4'd10,
    OP_BZ   = 4'd11,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_MEM, S_HALT
  } state_e;

  // Flags vector is {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational ALU for register-register and shift ops; returns result and {Z,C,N,O}.
module alu_seq_alu
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            c;
  logic            o;

  // Operation select plus carry/overflow; C is a borrow for SUB
  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    o      = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        o      = (a[M] == b[M]) && (result[M] != a[M]);
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
        o      = (a[M] != b[M]) && (result[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LSL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[M];
      end
      OP_LSR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      default: result = '0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_N] = result[M];
    flags[FLAG_O] = o;
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle 16-bit-instruction sequencer with byte-wide memory port and 8 x DATA_W registers.
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic [7:0]        Mem_WrData,
  input  logic [7:0]        Mem_RdData,
  output logic              Busy,
  output logic              Halted,
  output logic [3:0]        Flags,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       IROut,
  input  logic [2:0]        DbgSel,
  output logic [DATA_W-1:0] DbgData
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);

  state_e                 state;
  logic [ADDR_W-1:0]      pc;
  logic [15:0]            ir;
  logic [7:0][DATA_W-1:0] regs;
  logic [3:0]             flags;
  logic                   busy, halted;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_cs, mem_wr;
  logic [7:0]             mem_wdata;
  logic [CW-1:0]          byte_cnt;
  logic [DATA_W-1:0]      ld_buf;

  // Instruction fields
  opcode_e           op;
  logic [2:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_val, rs2_val, alu_res, ld_word;
  logic [3:0]        alu_flags;
  logic [ADDR_W-1:0] base, br_off, pc_exec_next;

  assign op      = opcode_e'(ir[15:12]);
  assign rd      = ir[11:9];
  assign rs1     = ir[8:6];
  assign rs2     = ir[5:3];
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign base    = ADDR_W'(rs1_val);
  assign br_off  = ADDR_W'($signed(ir[8:0]));
  // pc has already advanced past this instruction when EXEC runs
  assign pc_exec_next = (op == OP_BZ && flags[FLAG_Z]) ? pc + br_off : pc;

  alu_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (rs1_val),
    .b      (rs2_val),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Final LD word: lower bytes already captured, top byte arrives this cycle
  always_comb begin
    ld_word = ld_buf;
    ld_word[DATA_W-1 -: 8] = Mem_RdData;
  end

  // Sequencer FSM; memory strobes are registered so they are set up one state ahead
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      regs      <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      mem_addr  <= '0;
      mem_cs    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      byte_cnt  <= '0;
      ld_buf    <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state    <= S_FETCH0;
            pc       <= StartAddr;
            halted   <= 1'b0;
            busy     <= 1'b1;
            mem_cs   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= StartAddr;
          end
        end
        S_FETCH0: begin
          state    <= S_FETCH1;
          mem_addr <= pc + ADDR_W'(1);
        end
        S_FETCH1: begin
          ir[7:0] <= Mem_RdData;
          mem_cs  <= 1'b0;
          state   <= S_FETCH2;
        end
        S_FETCH2: begin
          ir[15:8] <= Mem_RdData;
          pc       <= pc + ADDR_W'(2);
          state    <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_LD: begin
              state    <= S_MEM;
              byte_cnt <= '0;
              mem_cs   <= 1'b1;
              mem_wr   <= 1'b0;
              mem_addr <= base;
            end
            OP_ST: begin
              state     <= S_MEM;
              byte_cnt  <= '0;
              mem_cs    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= base;
              mem_wdata <= rs2_val[7:0];
            end
            OP_HALT: begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
              mem_cs <= 1'b0;
            end
            default: begin
              if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR ||
                  op == OP_XOR || op == OP_LSL || op == OP_LSR) begin
                regs[rd] <= alu_res;
                flags    <= alu_flags;
              end else if (op == OP_LDI) begin
                regs[rd] <= DATA_W'(ir[7:0]);
              end
              pc       <= pc_exec_next;
              state    <= S_FETCH0;
              mem_cs   <= 1'b1;
              mem_wr   <= 1'b0;
              mem_addr <= pc_exec_next;
            end
          endcase
        end
        S_MEM: begin
          if (op == OP_ST) begin
            if (byte_cnt == CW'(NB - 1)) begin
              state    <= S_FETCH0;
              mem_wr   <= 1'b0;
              mem_addr <= pc;
            end else begin
              byte_cnt  <= byte_cnt + 1'b1;
              mem_addr  <= base + ADDR_W'(byte_cnt + 1'b1);
              mem_wdata <= rs2_val[8*(int'(byte_cnt)+1) +: 8];
            end
          end else begin
            // Read data trails its strobe by one cycle, so byte k lands at count k+1
            if (byte_cnt == CW'(NB)) begin
              regs[rd] <= ld_word;
              state    <= S_FETCH0;
              mem_cs   <= 1'b1;
              mem_addr <= pc;
            end else begin
              if (byte_cnt != '0)
                ld_buf[8*(int'(byte_cnt)-1) +: 8] <= Mem_RdData;
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt + 1'b1 < CW'(NB))
                mem_addr <= base + ADDR_W'(byte_cnt + 1'b1);
              else
                mem_cs <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Mem_Addr   = mem_addr;
  assign Mem_CS     = mem_cs;
  assign Mem_WR     = mem_wr;
  assign Mem_WrData = mem_wdata;
  assign Busy       = busy;
  assign Halted     = halted;
  assign Flags      = flags;
  assign PC         = pc;
  assign IROut      = ir;
  assign DbgData    = regs[DbgSel];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench: byte memory model, write/read-address scoreboards, register expectation queue.
module tb_alu_exec_sequencer;

  logic        Clock, Reset_n, Start;
  logic [15:0] StartAddr, Mem_Addr;
  logic        Mem_CS, Mem_WR;
  logic [7:0]  Mem_WrData, Mem_RdData;
  logic        Busy, Halted;
  logic [3:0]  Flags;
  logic [15:0] PC, IROut;
  logic [2:0]  DbgSel;
  logic [15:0] DbgData;

  logic [7:0] mem [0:65535];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit trk_rd = 1'b0;

  typedef struct { logic [2:0] idx; logic [15:0] val; } exp_t;
  exp_t        reg_q[$];
  logic [23:0] wr_q[$];
  logic [15:0] rd_q[$];
  int          wr_cyc[$];

  alu_exec_sequencer #(.DATA_W(16), .ADDR_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Mem_Addr(Mem_Addr), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .Mem_WrData(Mem_WrData),
    .Mem_RdData(Mem_RdData), .Busy(Busy), .Halted(Halted), .Flags(Flags),
    .PC(PC), .IROut(IROut), .DbgSel(DbgSel), .DbgData(DbgData)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Byte memory: read data valid the cycle after the strobe
  always @(posedge Clock) begin
    if (Mem_CS && !Mem_WR) Mem_RdData <= mem[Mem_Addr];
    if (Mem_CS && Mem_WR)  mem[Mem_Addr] <= Mem_WrData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard
  always @(negedge Clock) begin
    if (Reset_n && Mem_CS && Mem_WR) begin
      if (wr_q.size() == 0) chk("wr_pending", 32'(wr_q.size()), 32'd1);
      else begin
        chk("wr", {8'h0, Mem_Addr, Mem_WrData}, {8'h0, wr_q.pop_front()});
        wr_cyc.push_back(cyc);
      end
    end
  end

  // Read-address scoreboard, enabled per test
  always @(negedge Clock) begin
    if (Reset_n && trk_rd && Mem_CS && !Mem_WR) begin
      if (rd_q.size() == 0) chk("rd_pending", 32'(rd_q.size()), 32'd1);
      else chk("rd_addr", Mem_Addr, rd_q.pop_front());
    end
  end

  task automatic put16(input logic [15:0] a, input logic [15:0] v);
    mem[a]         <= v[7:0];
    mem[a + 16'd1] <= v[15:8];
  endtask

  task automatic start_pulse(input logic [15:0] a);
    @(negedge Clock);
    StartAddr = a;
    Start     = 1'b1;
    @(negedge Clock);
    Start     = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, output int bc);
    bc = 0;
    for (int i = 0; i < maxc && !Halted; i++) begin
      if (Busy) bc++;
      @(negedge Clock);
    end
    chk("halt_seen", {31'h0, Halted}, 32'd1);
  endtask

  task automatic exp_reg(input logic [2:0] idx, input logic [15:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    reg_q.push_back(e);
  endtask

  task automatic drain_regs();
    exp_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      DbgSel = e.idx;
      #1;
      chk($sformatf("R%0d", e.idx), DbgData, e.val);
    end
  endtask

  initial begin
    int bc;
    logic [7:0]  a, b;
    logic [15:0] r;
    logic        hit;
    Reset_n = 1'b0; Start = 1'b0; StartAddr = '0; DbgSel = '0;

    // A: 0x0000 LDI R1,0x20; LD R2,[R1]; LDI R3,1; ADD R4,R2,R3; HALT
    mem[16'h0020] <= 8'hFF; mem[16'h0021] <= 8'hFF;
    put16(16'h0000, 16'h8220); put16(16'h0002, 16'h9440); put16(16'h0004, 16'h8601);
    put16(16'h0006, 16'h1898); put16(16'h0008, 16'hF000);
    // D: BZ -4 at 0xFFFE, HALT at 0xFFFC
    put16(16'hFFFE, 16'hB1FC); put16(16'hFFFC, 16'hF000);
    // B: LDI R1,5; LDI R2,7; SUB R3,R1,R2; BZ +2 (not taken); LDI R7,0x55; HALT
    put16(16'h0100, 16'h8205); put16(16'h0102, 16'h8407); put16(16'h0104, 16'h2650);
    put16(16'h0106, 16'hB002); put16(16'h0108, 16'h8E55); put16(16'h010A, 16'hF000);
    // C: LDI R7,0x80; LD R4,[R7]; LDI R5,0x40; ST [R5],R4; LD R6,[R5]; HALT
    mem[16'h0080] <= 8'hEF; mem[16'h0081] <= 8'hBE;
    put16(16'h0200, 16'h8E80); put16(16'h0202, 16'h99C0); put16(16'h0204, 16'h8A40);
    put16(16'h0206, 16'hA160); put16(16'h0208, 16'h9D40); put16(16'h020A, 16'hF000);
    // E: LDI R1,0x11; LDI R1,0x22; HALT   (decoy at 0x0400: LDI R1,0x99; HALT)
    put16(16'h0300, 16'h8211); put16(16'h0302, 16'h8222); put16(16'h0304, 16'hF000);
    put16(16'h0400, 16'h8299); put16(16'h0402, 16'hF000);
    // F: LDI R1,0x20; LD R2,[R1]; HALT
    put16(16'h0500, 16'h8220); put16(16'h0502, 16'h9440); put16(16'h0504, 16'hF000);

    repeat (2) @(negedge Clock);
    chk("rst_busy",   {31'h0, Busy},   32'd0);
    chk("rst_halted", {31'h0, Halted}, 32'd0);
    chk("rst_cs",     {31'h0, Mem_CS}, 32'd0);
    chk("rst_pc",     PC,    32'd0);
    chk("rst_ir",     IROut, 32'd0);
    chk("rst_flags",  Flags, 32'd0);
    for (int i = 0; i < 8; i++) exp_reg(3'(i), 16'h0000);
    drain_regs();
    Reset_n = 1'b1;

    // A: LD of 0xFFFF then +1 wraps to zero with carry
    start_pulse(16'h0000);
    wait_halt(100, bc);
    chk("a_busy_cycles", bc, 32'd23);
    exp_reg(3'd2, 16'hFFFF);
    exp_reg(3'd4, 16'h0000);
    drain_regs();
    chk("a_flags", Flags, 32'b1100);

    // D: taken branch across the address wrap
    rd_q.push_back(16'hFFFE); rd_q.push_back(16'hFFFF);
    rd_q.push_back(16'hFFFC); rd_q.push_back(16'hFFFD);
    trk_rd = 1'b1;
    start_pulse(16'hFFFE);
    repeat (3) @(negedge Clock);
    chk("d_pc_wrap", PC, 32'h0000);
    chk("d_ir", IROut, 32'hB1FC);
    @(negedge Clock);
    chk("d_pc_br", PC, 32'hFFFC);
    wait_halt(50, bc);
    trk_rd = 1'b0;
    chk("d_rd_left", 32'(rd_q.size()), 32'd0);
    chk("d_pc_end", PC, 32'hFFFE);

    // B: SUB with borrow, untaken BZ
    start_pulse(16'h0100);
    wait_halt(100, bc);
    exp_reg(3'd3, 16'hFFFE);
    exp_reg(3'd7, 16'h0055);
    drain_regs();
    chk("b_flags", Flags, 32'b0110);

    // C: little-endian ST in consecutive cycles, LD back
    wr_q.push_back({16'h0040, 8'hEF});
    wr_q.push_back({16'h0041, 8'hBE});
    wr_cyc.delete();
    start_pulse(16'h0200);
    wait_halt(100, bc);
    chk("c_wr_left", 32'(wr_q.size()), 32'd0);
    chk("c_wr_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) chk("c_st_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
    exp_reg(3'd4, 16'hBEEF);
    exp_reg(3'd6, 16'hBEEF);
    drain_regs();
    chk("c_flags_kept", Flags, 32'b0110);

    // E: restart from HALT, Start ignored while busy
    start_pulse(16'h0300);
    chk("e_halted_clr", {31'h0, Halted}, 32'd0);
    chk("e_busy_set",   {31'h0, Busy},   32'd1);
    @(negedge Clock);
    StartAddr = 16'h0400;
    Start     = 1'b1;
    @(negedge Clock);
    Start     = 1'b0;
    wait_halt(100, bc);
    exp_reg(3'd1, 16'h0022);
    drain_regs();
    chk("e_busy_end", {31'h0, Busy},   32'd0);
    chk("e_cs_halt",  {31'h0, Mem_CS}, 32'd0);
    chk("e_pc_end",   PC, 32'h0306);

    // G: logic ops and shifts on random bytes
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      put16(16'h0600, {8'h82, a}); put16(16'h0602, {8'h84, b});
      put16(16'h0604, 16'h3650);   put16(16'h0606, 16'h4850);
      put16(16'h0608, 16'h5A50);   put16(16'h060A, 16'h6C40);
      put16(16'h060C, 16'h7E80);   put16(16'h060E, 16'hF000);
      start_pulse(16'h0600);
      wait_halt(100, bc);
      r = {8'h0, b} >> 1;
      exp_reg(3'd3, {8'h0, a & b});
      exp_reg(3'd4, {8'h0, a | b});
      exp_reg(3'd5, {8'h0, a ^ b});
      exp_reg(3'd6, {7'h0, a, 1'b0});
      exp_reg(3'd7, r);
      drain_regs();
      chk("g_flags", Flags, {28'h0, (r == 16'h0), b[0], 2'b00});
    end

    // F: reset in the middle of an LD burst
    start_pulse(16'h0500);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (Mem_CS && !Mem_WR && Mem_Addr == 16'h0020) hit = 1'b1;
      else @(negedge Clock);
    end
    chk("f_burst_seen", {31'h0, hit}, 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("f_cs",    {31'h0, Mem_CS}, 32'd0);
    chk("f_busy",  {31'h0, Busy},   32'd0);
    chk("f_pc",    PC,    32'd0);
    chk("f_ir",    IROut, 32'd0);
    chk("f_flags", Flags, 32'd0);
    @(negedge Clock);
    chk("f_cs_next",   {31'h0, Mem_CS}, 32'd0);
    chk("f_wr_next",   {31'h0, Mem_WR}, 32'd0);
    chk("f_addr_next", Mem_Addr, 32'd0);
    for (int i = 0; i < 8; i++) exp_reg(3'(i), 16'h0000);
    drain_regs();
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);
    chk("f_idle_busy", {31'h0, Busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
